// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared types and constants for the RV32 multi-cycle sequencer
package rv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'b00,
        HC_ILLEGAL = 2'b01,
        HC_TIMEOUT = 2'b10
    } halt_cause_t;

    // Opcodes the datapath can execute; the decoder uses the same constants.
    localparam logic [6:0]  OP_R     = 7'b0110011;
    localparam logic [6:0]  OP_I_ALU = 7'b0010011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h00000013;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_ALU);
    endfunction

endpackage

// File: rtl/rv_seq_ctrl.sv
// rtl/rv_seq_ctrl.sv - FETCH/DECODE/EXEC/WB sequencer owning PC and instruction register
module rv_seq_ctrl
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h00000000,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst_q,
    input  logic             dec_w_en,
    output logic             alu_lat_en,
    output logic             rf_we,
    output logic [31:0]      pc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic [1:0]       halt_cause
);

    // The counter never needs to hold more than FETCH_TIMEOUT-1.
    localparam int TMO_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((FETCH_TIMEOUT > 0) ? FETCH_TIMEOUT - 1 : 0);
    localparam logic TMO_ON = (FETCH_TIMEOUT > 0);

    state_t           state_q;
    state_t           state_d;
    logic [TMO_W-1:0] tmo_cnt;
    halt_cause_t      cause_q;

    // Moore strobes; rf_we additionally qualified by the decoder and x0 suppression.
    assign imem_req   = (state_q == ST_FETCH);
    assign imem_addr  = pc;
    assign alu_lat_en = (state_q == ST_EXEC);
    assign retire     = (state_q == ST_WB);
    assign rf_we      = (state_q == ST_WB) && dec_w_en && (inst_q[11:7] != 5'd0);
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = cause_q;

    // Next-state decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)
                    state_d = ST_DECODE;
                else if (TMO_ON && (tmo_cnt == TMO_LAST))
                    state_d = ST_HALT;
            end
            ST_DECODE: begin
                state_d = is_legal_op(inst_q[6:0]) ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Instruction register captures the fetched word on ack; acks elsewhere are dropped.
    always_ff @(posedge clk) begin
        if (rst)
            inst_q <= NOP_INST;
        else if ((state_q == ST_FETCH) && imem_ack)
            inst_q <= imem_rdata;
    end

    // Fetch wait counter: runs only while FETCH waits for an ack, cleared otherwise.
    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (TMO_ON && (state_q == ST_FETCH) && !imem_ack)
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        else
            tmo_cnt <= '0;
    end

    // Halt cause is recorded on the transition into HALT and then held.
    always_ff @(posedge clk) begin
        if (rst)
            cause_q <= HC_NONE;
        else if (state_d == ST_HALT) begin
            if (state_q == ST_FETCH)
                cause_q <= HC_TIMEOUT;
            else if (state_q == ST_DECODE)
                cause_q <= HC_ILLEGAL;
        end
    end

    // PC and retired-instruction count advance only in WB, both wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            instret <= '0;
        end else if (state_q == ST_WB) begin
            pc      <= pc + 32'd4;
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rv_seq_ctrl.sv
// tb/tb_rv_seq_ctrl.sv - scoreboard bench for rv_seq_ctrl
module tb_rv_seq_ctrl;
    import rv_pkg::*;

    localparam logic [31:0] I_ADD    = 32'h002081B3;
    localparam logic [31:0] I_ADDI0  = 32'h00500013;
    localparam logic [31:0] I_SYSTEM = 32'h00000073;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, imem_req, imem_ack, dec_w_en, alu_lat_en, rf_we, retire, halted;
    logic [31:0] imem_addr, imem_rdata, inst_q, pc, instret;
    logic [1:0]  halt_cause;

    logic        run_w, imem_req_w, imem_ack_w, alu_lat_en_w, rf_we_w, retire_w, halted_w;
    logic [31:0] imem_addr_w, imem_rdata_w, inst_q_w, pc_w;
    logic [7:0]  instret_w;
    logic [1:0]  halt_cause_w;

    rv_seq_ctrl #(.RESET_PC(32'h00000100), .FETCH_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_q(inst_q), .dec_w_en(dec_w_en),
        .alu_lat_en(alu_lat_en), .rf_we(rf_we), .pc(pc), .retire(retire), .instret(instret),
        .halted(halted), .halt_cause(halt_cause)
    );

    rv_seq_ctrl #(.RESET_PC(32'hFFFFFFFC), .FETCH_TIMEOUT(0), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst), .run(run_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .inst_q(inst_q_w), .dec_w_en(1'b1),
        .alu_lat_en(alu_lat_en_w), .rf_we(rf_we_w), .pc(pc_w), .retire(retire_w),
        .instret(instret_w), .halted(halted_w), .halt_cause(halt_cause_w)
    );

    assign imem_ack_w   = imem_req_w;
    assign imem_rdata_w = 32'h00100093;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Instruction memory: answers after mem_wait wait cycles when enabled.
    logic [31:0] mem [logic [31:0]];
    logic        ack_en;
    int          mem_wait;
    int          wcnt = 0;

    always @(negedge clk) begin
        if (imem_req && ack_en) begin
            if (wcnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem.exists(imem_addr) ? mem[imem_addr] : NOP_INST;
                wcnt       = 0;
            end else begin
                imem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            wcnt     = 0;
        end
    end

    // Scoreboard of expected retirements and halts.
    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [31:0] inst;
    } ret_t;

    ret_t        sb [$];
    logic [1:0]  hq [$];
    ret_t        mon_e;
    logic [1:0]  mon_h;
    logic        halted_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst && retire) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ret_pc", pc, mon_e.pc);
                check("ret_rf_we", rf_we, mon_e.rf_we);
                check("ret_inst", inst_q, mon_e.inst);
            end
        end
        if (halted && !halted_prev) begin
            if (hq.size() == 0) begin
                check("unexpected_halt", 64'd1, 64'd0);
            end else begin
                mon_h = hq.pop_front();
                check("halt_cause_mon", halt_cause, mon_h);
            end
        end
        halted_prev = halted;
    end

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_halt(input string name);
        for (int i = 0; i < 40; i++) begin
            if (halted) break;
            tick();
        end
        check(name, halted, 1'b1);
    endtask

    // PC wrap check on the second instance.
    logic wrap_done = 1'b0;
    initial begin
        run_w = 1'b0;
        wait (run_w);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (retire_w) break;
        end
        check("wrap_retire_seen", retire_w, 1'b1);
        check("wrap_pc_in_wb", pc_w, 32'hFFFFFFFC);
        run_w = 1'b0;
        tick();
        check("wrap_pc_after", pc_w, 32'h0);
        check("wrap_instret", instret_w, 8'd1);
        check("wrap_idle_req", imem_req_w, 1'b0);
        wrap_done = 1'b1;
    end

    initial begin
        int req_cycles;
        rst = 1'b1; run = 1'b0; dec_w_en = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        ack_en = 1'b1; mem_wait = 0;
        mem[32'h100] = I_ADD;
        mem[32'h104] = I_ADDI0;
        mem[32'h108] = I_SYSTEM;
        tick();
        tick();

        check("rst_pc", pc, 32'h100);
        check("rst_inst_q", inst_q, NOP_INST);
        check("rst_instret", instret, 32'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_cause", halt_cause, 2'b00);
        check("rst_strobes", {imem_req, alu_lat_en, rf_we, retire}, 4'b0000);

        // ADD, ADDI to x0, then SYSTEM halts
        sb.push_back('{pc: 32'h100, rf_we: 1'b1, inst: I_ADD});
        sb.push_back('{pc: 32'h104, rf_we: 1'b0, inst: I_ADDI0});
        hq.push_back(2'b01);
        rst = 1'b0; run = 1'b1; run_w = 1'b1;
        tick();
        check("c1_req", imem_req, 1'b1);
        check("c1_addr", imem_addr, 32'h100);
        check("c1_alu", alu_lat_en, 1'b0);
        tick();
        check("c2_inst_q", inst_q, I_ADD);
        check("c2_req", imem_req, 1'b0);
        tick();
        check("c3_alu", alu_lat_en, 1'b1);
        check("c3_rf_we", rf_we, 1'b0);
        tick();
        check("c4_rf_we", rf_we, 1'b1);
        check("c4_retire", retire, 1'b1);
        check("c4_alu", alu_lat_en, 1'b0);
        tick();
        check("c5_pc", pc, 32'h104);
        check("c5_instret", instret, 32'd1);
        check("c5_addr", imem_addr, 32'h104);
        repeat (3) tick();
        check("addi_retire", retire, 1'b1);
        check("addi_rf_we", rf_we, 1'b0);
        tick();
        check("addi_pc", pc, 32'h108);
        wait_halt("illegal_halt_seen");
        check("ill_cause", halt_cause, 2'b01);
        check("ill_pc", pc, 32'h108);
        check("ill_instret", instret, 32'd2);
        check("ill_req", imem_req, 1'b0);
        repeat (5) tick();
        check("ill_hold", {halted, retire, imem_req}, 3'b100);
        check("ill_hold_pc", pc, 32'h108);

        // fetch timeout
        do_reset();
        ack_en = 1'b0;
        hq.push_back(2'b10);
        rst = 1'b0; run = 1'b1;
        req_cycles = 0;
        repeat (30) begin
            tick();
            if (imem_req) req_cycles++;
        end
        check("tmo_req_cycles", req_cycles, 16);
        check("tmo_halted", halted, 1'b1);
        check("tmo_cause", halt_cause, 2'b10);
        check("tmo_pc", pc, 32'h100);

        // run dropped during EXEC
        do_reset();
        ack_en = 1'b1; mem_wait = 0;
        sb.push_back('{pc: 32'h100, rf_we: 1'b1, inst: I_ADD});
        rst = 1'b0; run = 1'b1;
        tick();
        tick();
        tick();
        check("r5_exec", alu_lat_en, 1'b1);
        run = 1'b0;
        tick();
        check("r5_retire", retire, 1'b1);
        tick();
        check("r5_idle_req", imem_req, 1'b0);
        check("r5_pc", pc, 32'h104);
        check("r5_instret", instret, 32'd1);
        repeat (3) tick();
        check("r5_still_idle", imem_req, 1'b0);
        sb.push_back('{pc: 32'h104, rf_we: 1'b0, inst: I_ADDI0});
        hq.push_back(2'b01);
        run = 1'b1;
        tick();
        check("r5_resume_req", imem_req, 1'b1);
        check("r5_resume_addr", imem_addr, 32'h104);
        wait_halt("r5_halt_seen");
        check("r5_halt_pc", pc, 32'h108);
        check("r5_halt_instret", instret, 32'd2);

        // reset during a waited fetch, with an ack in the reset cycle
        do_reset();
        mem_wait = 3;
        rst = 1'b0; run = 1'b1;
        tick();
        tick();
        check("r6_waiting", {imem_req, imem_ack}, 2'b10);
        #1;
        rst = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        check("r6_req", imem_req, 1'b0);
        check("r6_pc", pc, 32'h100);
        check("r6_instret", instret, 32'd0);
        check("r6_inst_q", inst_q, NOP_INST);
        check("r6_halted", halted, 1'b0);
        rst = 1'b0; run = 1'b0;
        tick();
        tick();
        check("r6_late_ack_ignored", inst_q, NOP_INST);
        check("r6_idle", imem_req, 1'b0);

        for (int i = 0; i < 50; i++) begin
            if (wrap_done) break;
            tick();
        end
        check("wrap_done", wrap_done, 1'b1);
        check("sb_drained", sb.size(), 0);
        check("hq_drained", hq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
